// File: rtl/gumnut_ctrl_pkg.sv
// gumnut_pkg: shared states, PC operation codes, instruction classes and opcode masks
package gumnut_pkg;
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2, S_MEM = 3'd3, S_WRITEBACK = 3'd4, S_INT = 3'd5
  } state_e;
  typedef enum logic [2:0] {C_ALU, C_MEM, C_BRANCH, C_JUMP, C_MISC, C_NOP} class_e;
  localparam int PC_INC = 0, PC_BZ = 1, PC_BNZ = 2, PC_BC = 3, PC_BNC = 4;
  localparam int PC_JMP = 8, PC_RET = 10, PC_INTVEC = 12, PC_RETI = 13;
  // masks and match values on opcode bits IR[17:8]
  localparam logic [9:0] M_MEM = 10'h3C0, V_MEM = 10'h380;
  localparam logic [9:0] M_BR = 10'h3F0, V_BR = 10'h3E0;
  localparam logic [9:0] M_JMP = 10'h3E0, V_JMP = 10'h3C0;
  localparam logic [9:0] M_MISC = 10'h3F8, V_MISC = 10'h3F0;
  localparam logic [2:0] MI_RET = 3'd0, MI_RETI = 3'd1, MI_ENAI = 3'd2, MI_DISI = 3'd3;
endpackage

// File: rtl/gumnut_ctrl_if.sv
// gumnut_ctrl_if: instruction/data handshakes and control strobes of the sequencer
interface gumnut_ctrl_if #(parameter int PCOP_W = 4);
  logic [17:0] inst_i;
  logic inst_ack_i, data_ack_i, int_req_i;
  logic inst_cyc_o, IREn_c_o, PCEn_c_o, int_c_o, reti_c_o, RegWr_c_o, ccEn_c_o;
  logic [PCOP_W-1:0] PCoper_c_o;
  logic stack_push_c_o, stack_pop_c_o, data_cyc_o, data_we_o, data_port_o, int_ack_o, ie_o;
  logic [2:0] state_o;
  modport master(
    input inst_i, inst_ack_i, data_ack_i, int_req_i,
    output inst_cyc_o, IREn_c_o, PCoper_c_o, PCEn_c_o, int_c_o, reti_c_o, RegWr_c_o, ccEn_c_o,
    output stack_push_c_o, stack_pop_c_o, data_cyc_o, data_we_o, data_port_o, int_ack_o, ie_o, state_o
  );
  modport slave(
    output inst_i, inst_ack_i, data_ack_i, int_req_i,
    input inst_cyc_o, IREn_c_o, PCoper_c_o, PCEn_c_o, int_c_o, reti_c_o, RegWr_c_o, ccEn_c_o,
    input stack_push_c_o, stack_pop_c_o, data_cyc_o, data_we_o, data_port_o, int_ack_o, ie_o, state_o
  );
endinterface

// File: rtl/gumnut_ctrl_decode.sv
// gumnut_decode: combinational opcode classifier, first matching prefix wins
module gumnut_decode
  import gumnut_pkg::*;
(
  input  logic [9:0] op,
  output class_e     cls,
  output logic [1:0] mem_op,
  output logic [1:0] br_op,
  output logic       jsb,
  output logic [2:0] misc_op
);
  assign mem_op  = op[5:4];
  assign br_op   = op[3:2];
  assign jsb     = op[4];
  assign misc_op = op[2:0];
  // anything not starting 111 is arith-imm, arith-reg or shift
  assign cls = op[9:7] != 3'b111 ? C_ALU :
               (op & M_MEM) == V_MEM ? C_MEM :
               (op & M_BR) == V_BR ? C_BRANCH :
               (op & M_JMP) == V_JMP ? C_JUMP :
               (op & M_MISC) == V_MISC && op[2:1] != 2'b11 ? C_MISC : C_NOP;
endmodule

// File: rtl/gumnut_ctrl.sv
// gumnut_ctrl: fetch/decode/execute/mem/writeback sequencer with interrupt entry and ie flag
module gumnut_ctrl
  import gumnut_pkg::*;
#(
  parameter int PCOP_W = 4
) (
  input logic clk_i,
  input logic rst_i,
  input logic ClkEn_i,
  gumnut_ctrl_if.master bus
);
  state_e state, nxt;
  logic ie, ie_nxt, jsb, take_int;
  logic [9:0] ir;
  logic [3:0] pcop;
  logic [1:0] mem_op, br_op;
  logic [2:0] misc_op;
  class_e cls;
  state_e done;
  gumnut_decode u_dec (.op(ir), .cls(cls), .mem_op(mem_op), .br_op(br_op), .jsb(jsb), .misc_op(misc_op));
  // ie is sampled before any update made in the same cycle
  assign take_int = bus.int_req_i && ie;
  assign done = take_int ? S_INT : S_FETCH;
  assign bus.PCoper_c_o = PCOP_W'(pcop);
  assign bus.ie_o = ie;
  assign bus.state_o = state;
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      state <= S_FETCH;
      ie <= 1'b0;
      ir <= '0;
    end else if (ClkEn_i) begin
      state <= nxt;
      ie <= ie_nxt;
      if (bus.IREn_c_o) ir <= bus.inst_i[17:8];
    end
  always_comb begin
    nxt = state;
    ie_nxt = ie;
    pcop = 4'(PC_INC);
    bus.inst_cyc_o = 1'b0;
    bus.IREn_c_o = 1'b0;
    bus.PCEn_c_o = 1'b0;
    bus.int_c_o = 1'b0;
    bus.reti_c_o = 1'b0;
    bus.RegWr_c_o = 1'b0;
    bus.ccEn_c_o = 1'b0;
    bus.stack_push_c_o = 1'b0;
    bus.stack_pop_c_o = 1'b0;
    bus.data_cyc_o = 1'b0;
    bus.data_we_o = 1'b0;
    bus.data_port_o = 1'b0;
    bus.int_ack_o = 1'b0;
    case (state)
      S_FETCH: begin
        bus.inst_cyc_o = 1'b1;
        bus.IREn_c_o = bus.inst_ack_i;
        nxt = bus.inst_ack_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.PCEn_c_o = 1'b1;
        nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        nxt = done;
        case (cls)
          C_ALU: begin
            bus.ccEn_c_o = 1'b1;
            nxt = S_WRITEBACK;
          end
          C_MEM: nxt = S_MEM;
          C_BRANCH: begin
            bus.PCEn_c_o = 1'b1;
            pcop = 4'(PC_BZ) + {2'b00, br_op};
          end
          C_JUMP: begin
            bus.PCEn_c_o = 1'b1;
            pcop = 4'(PC_JMP);
            bus.stack_push_c_o = jsb;
          end
          C_MISC:
            case (misc_op)
              MI_RET: begin
                bus.PCEn_c_o = 1'b1;
                pcop = 4'(PC_RET);
                bus.stack_pop_c_o = 1'b1;
              end
              MI_RETI: begin
                bus.PCEn_c_o = 1'b1;
                pcop = 4'(PC_RETI);
                bus.reti_c_o = 1'b1;
                ie_nxt = 1'b1;
              end
              MI_ENAI: ie_nxt = 1'b1;
              MI_DISI: ie_nxt = 1'b0;
              default: nxt = take_int ? S_INT : S_EXECUTE;
            endcase
          default: ;
        endcase
      end
      S_MEM: begin
        bus.data_cyc_o = 1'b1;
        bus.data_we_o = mem_op[0];
        bus.data_port_o = mem_op[1];
        if (bus.data_ack_i) nxt = mem_op[0] ? done : S_WRITEBACK;
      end
      S_WRITEBACK: begin
        bus.RegWr_c_o = 1'b1;
        nxt = done;
      end
      S_INT: begin
        bus.int_c_o = 1'b1;
        bus.PCEn_c_o = 1'b1;
        bus.int_ack_o = 1'b1;
        pcop = 4'(PC_INTVEC);
        ie_nxt = 1'b0;
        nxt = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end
endmodule
